// File: rtl/reg_pkg.sv
// Shared constants, FSM state type and bit/register-number mapping for reg_encoder.
// Register n is carried on request bit NUM_REGS-1-n, the same order as the enable bus.
package reg_pkg;

    localparam int NUM_REGS = 8;
    localparam int NUM_W    = 16;
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // The mapping is its own inverse, so it serves both directions.
    function automatic logic [IDX_W-1:0] bit_to_reg(input logic [IDX_W-1:0] idx);
        return IDX_W'(NUM_REGS - 1) - idx;
    endfunction

endpackage

// File: rtl/reg_encoder_if.sv
// Offer/acknowledge bus between the register requesters, reg_encoder and its consumer.
interface reg_encoder_if;
    import reg_pkg::*;

    logic [NUM_REGS-1:0] reg_req;
    logic [NUM_W-1:0]    reg_num;
    logic                num_valid;
    logic                num_ready;
    logic [NUM_REGS-1:0] reg_ack;
    logic                busy;

    modport slave (
        input  reg_req,
        input  num_ready,
        output reg_num,
        output num_valid,
        output reg_ack,
        output busy
    );

    modport master (
        output reg_req,
        output num_ready,
        input  reg_num,
        input  num_valid,
        input  reg_ack,
        input  busy
    );

endinterface

// File: rtl/reg_prio_sel.sv
// Combinational requester search: first requesting register at or after start_idx, wrapping.
module reg_prio_sel
    import reg_pkg::*;
(
    input  logic [NUM_REGS-1:0] req,
    input  logic [IDX_W-1:0]    start_idx,
    output logic [NUM_REGS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                found
);

    logic [IDX_W-1:0] reg_idx_s;

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        grant     = {NUM_REGS{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        found     = 1'b0;
        reg_idx_s = {IDX_W{1'b0}};
        for (int k = NUM_REGS - 1; k >= 0; k--) begin
            reg_idx_s = start_idx + IDX_W'(k);
            if (req[bit_to_reg(reg_idx_s)]) begin
                grant                        = {NUM_REGS{1'b0}};
                grant[bit_to_reg(reg_idx_s)] = 1'b1;
                grant_idx                    = reg_idx_s;
                found                        = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/reg_encoder.sv
// Register-request encoder: arbitrates reg_req, offers the register number, acks on handshake.
// Build option REG_ENCODER_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module reg_encoder #(
    parameter int NUM_REGS = reg_pkg::NUM_REGS,
    parameter int NUM_W    = reg_pkg::NUM_W
) (
    input  logic          clk,
    input  logic          rst,
    reg_encoder_if.slave  bus
);
    import reg_pkg::*;

    state_t              state_r, state_s;
    logic [NUM_W-1:0]    reg_num_r, reg_num_s;
    logic                num_valid_r, num_valid_s;
    logic [NUM_REGS-1:0] reg_ack_r, reg_ack_s;
    logic [NUM_REGS-1:0] grant_r, grant_s;
    logic                busy_r;

    logic [IDX_W-1:0]    start_idx_s;
    logic [NUM_REGS-1:0] sel_grant_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic                sel_found_s;
    logic                handshake_s;

    assign handshake_s = (state_r == OFFER) && bus.num_ready;

`ifdef REG_ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_r, ptr_s;

    assign start_idx_s = ptr_r + IDX_W'(1);

    // Pointer remembers the register granted by the last completed handshake.
    always_comb begin
        if (handshake_s) begin
            ptr_s = reg_num_r[IDX_W-1:0];
        end else begin
            ptr_s = ptr_r;
        end
    end

    // Round-robin pointer register; reset points at register 7 so register 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= IDX_W'(NUM_REGS - 1);
        end else begin
            ptr_r <= ptr_s;
        end
    end
`else
    assign start_idx_s = {IDX_W{1'b0}};
`endif

    reg_prio_sel u_sel (
        .req       (bus.reg_req),
        .start_idx (start_idx_s),
        .grant     (sel_grant_s),
        .grant_idx (sel_idx_s),
        .found     (sel_found_s)
    );

    // Next-state and next-output logic; requests are only looked at while IDLE.
    always_comb begin
        state_s     = state_r;
        reg_num_s   = reg_num_r;
        num_valid_s = num_valid_r;
        grant_s     = grant_r;
        reg_ack_s   = {NUM_REGS{1'b0}};
        case (state_r)
            IDLE: begin
                if (sel_found_s) begin
                    state_s     = OFFER;
                    reg_num_s   = NUM_W'(sel_idx_s);
                    num_valid_s = 1'b1;
                    grant_s     = sel_grant_s;
                end else begin
                    num_valid_s = 1'b0;
                end
            end
            OFFER: begin
                if (bus.num_ready) begin
                    state_s     = IDLE;
                    num_valid_s = 1'b0;
                    reg_ack_s   = grant_r;
                end else begin
                    num_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = IDLE;
                num_valid_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any pending offer without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            reg_num_r   <= {NUM_W{1'b0}};
            num_valid_r <= 1'b0;
            reg_ack_r   <= {NUM_REGS{1'b0}};
            grant_r     <= {NUM_REGS{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            reg_num_r   <= reg_num_s;
            num_valid_r <= num_valid_s;
            reg_ack_r   <= reg_ack_s;
            grant_r     <= grant_s;
            busy_r      <= (state_s != IDLE);
        end
    end

    assign bus.reg_num   = reg_num_r;
    assign bus.num_valid = num_valid_r;
    assign bus.reg_ack   = reg_ack_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_reg_encoder.sv
// Directed bench for reg_encoder: stimulus pushes expected grants, a negedge monitor checks them.
module tb_reg_encoder;

    logic clk;
    logic rst;

    reg_encoder_if bus_if ();

    reg_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic [15:0] num;
        logic [7:0]  ack;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_err;
    logic [7:0]  exp_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r);
        exp_t e;
        e.num = 16'(r);
        e.ack = 8'h80 >> r;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus_if.reg_req   = 8'h00;
        bus_if.num_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: checks every ack cycle and the offered number on each observed handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_ack = 8'h00;
        end else begin
            check("reg_ack", {8'h00, bus_if.reg_ack}, {8'h00, exp_ack});
            exp_ack = 8'h00;
            if (bus_if.num_valid && bus_if.num_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_handshake", bus_if.reg_num, 16'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("hs_reg_num", bus_if.reg_num, e.num);
                    exp_ack = e.ack;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_ack = 8'h00;
        rst     = 1'b1;
        bus_if.reg_req   = 8'h00;
        bus_if.num_ready = 1'b0;

        // Reset state
        #2;
        check("rst_valid", {15'd0, bus_if.num_valid}, 16'h0000);
        check("rst_num", bus_if.reg_num, 16'h0000);
        check("rst_ack", {8'h00, bus_if.reg_ack}, 16'h0000);
        check("rst_busy", {15'd0, bus_if.busy}, 16'h0000);
        tick();
        rst = 1'b0;

        // Single request, ready held high
        bus_if.reg_req   = 8'b00100000;
        bus_if.num_ready = 1'b1;
        push(2);
        tick();
        check("t1_valid", {15'd0, bus_if.num_valid}, 16'h0001);
        check("t1_num", bus_if.reg_num, 16'h0002);
        check("t1_busy", {15'd0, bus_if.busy}, 16'h0001);
        tick();
        check("t1_ack", {8'h00, bus_if.reg_ack}, 16'h0020);
        check("t1_valid_clr", {15'd0, bus_if.num_valid}, 16'h0000);
        bus_if.reg_req = 8'h00;
        tick();

        // Stalled offer stays stable, lowest register wins
        do_reset();
        bus_if.reg_req = 8'b10000001;
        push(0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", {15'd0, bus_if.num_valid}, 16'h0001);
            check("t2_num", bus_if.reg_num, 16'h0000);
            check("t2_ack", {8'h00, bus_if.reg_ack}, 16'h0000);
            tick();
        end
        bus_if.num_ready = 1'b1;
        tick();
        check("t2_ack_hs", {8'h00, bus_if.reg_ack}, 16'h0080);
        bus_if.reg_req = 8'h00;
        tick();
        check("t2_ack_once", {8'h00, bus_if.reg_ack}, 16'h0000);

        // All requests, nine handshakes
        do_reset();
        bus_if.reg_req   = 8'hFF;
        bus_if.num_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
`ifdef REG_ENCODER_ROUND_ROBIN_EN
            push(i % 8);
`else
            push(0);
`endif
        end
        for (int i = 0; i < 18; i++) tick();
        bus_if.reg_req = 8'h00;
        tick();
        tick();
        check("t3_drained", 16'(sb_q.size()), 16'h0000);

        // Requester drops during offer, new request ignored until IDLE
        do_reset();
        bus_if.reg_req = 8'b00010000;
        push(3);
        tick();
        check("t4_num", bus_if.reg_num, 16'h0003);
        bus_if.reg_req = 8'b10000000;
        tick();
        check("t4_num_hold", bus_if.reg_num, 16'h0003);
        check("t4_valid_hold", {15'd0, bus_if.num_valid}, 16'h0001);
        bus_if.num_ready = 1'b1;
        push(0);
        tick();
        check("t4_ack", {8'h00, bus_if.reg_ack}, 16'h0010);
        tick();
        check("t4_next_num", bus_if.reg_num, 16'h0000);
        bus_if.reg_req = 8'h00;
        tick();
        check("t4_next_ack", {8'h00, bus_if.reg_ack}, 16'h0080);
        tick();

        // Asynchronous reset mid-offer
        do_reset();
        bus_if.reg_req = 8'b00000001;
        tick();
        check("t5_valid", {15'd0, bus_if.num_valid}, 16'h0001);
        check("t5_num", bus_if.reg_num, 16'h0007);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", {15'd0, bus_if.num_valid}, 16'h0000);
        check("t5_rst_num", bus_if.reg_num, 16'h0000);
        check("t5_rst_ack", {8'h00, bus_if.reg_ack}, 16'h0000);
        check("t5_rst_busy", {15'd0, bus_if.busy}, 16'h0000);
        bus_if.reg_req   = 8'h00;
        bus_if.num_ready = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_ack", {8'h00, bus_if.reg_ack}, 16'h0000);
            check("t5_no_valid", {15'd0, bus_if.num_valid}, 16'h0000);
        end

        // Idle with ready toggling
        for (int i = 0; i < 10; i++) begin
            bus_if.num_ready = ~bus_if.num_ready;
            tick();
            check("t6_valid", {15'd0, bus_if.num_valid}, 16'h0000);
            check("t6_ack", {8'h00, bus_if.reg_ack}, 16'h0000);
            check("t6_busy", {15'd0, bus_if.busy}, 16'h0000);
        end

        tick();
        check("sb_empty", 16'(sb_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_encoder.md
REG_ENCODER -- requirements
Module: reg_encoder

Interface
REQ-001 Parameter NUM_REGS, default 8: number of register request lines; fixed at 8 in this release.
REQ-002 Parameter NUM_W, default 16: width of the encoded register number.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port reg_req, input, 8: level requests; bit 7 = register 0 ... bit 0 = register 7 (same bit order as the register enable bus).
REQ-006 Port reg_num, output, 16: encoded register number of the current offer; bits 15:3 always zero.
REQ-007 Port num_valid, output, 1: reg_num holds a valid offer.
REQ-008 Port num_ready, input, 1: downstream accepts the offer.
REQ-009 Port reg_ack, output, 8: one-hot, one-cycle pulse to the granted requester on handshake; same bit order as reg_req.
REQ-010 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and OFFER, registered, all outputs registered.
REQ-012 IDLE, reg_req == 0: SHALL remain IDLE; num_valid = 0, reg_num holds its last value.
REQ-013 IDLE, reg_req != 0: SHALL select one requester per arbitration rule, load reg_num = its register number, set num_valid = 1, go to OFFER; latency 1 cycle from the sampling edge to num_valid high.
REQ-014 OFFER: reg_num and num_valid SHALL stay stable until the handshake (num_valid && num_ready at a rising edge).
REQ-015 OFFER handshake: SHALL pulse reg_ack for exactly the granted bit for one cycle, clear num_valid, return to IDLE; maximum throughput one grant per 2 cycles.
REQ-016 Requester dropping reg_req during OFFER SHALL NOT retract the offer; the ack is still issued.
REQ-017 New or changed reg_req bits during OFFER SHALL be ignored until the next IDLE evaluation.
REQ-018 num_ready high while in IDLE SHALL have no effect.
REQ-019 reg_ack SHALL be zero in every cycle without a handshake on the preceding edge.

Reset
REQ-020 On rst high: state = IDLE, num_valid = 0, reg_num = 0, reg_ack = 0, busy = 0, round-robin pointer = register 7, immediately and independent of clk.
REQ-021 rst asserted during OFFER SHALL abandon the offer with no reg_ack pulse; the first evaluation after release restarts arbitration.

Configuration
REQ-022 Macro REG_ENCODER_ROUND_ROBIN_EN defined: arbitration SHALL search starting at the register after the last granted one, wrapping 7 -> 0; pointer updates only on handshake.
REQ-023 Macro undefined: fixed priority, lowest register number (bit 7) wins; the pointer SHALL not exist.
REQ-024 Both builds SHALL grant register 0 first when all requests are raised after reset.

Structure
REQ-025 Shared package reg_pkg SHALL hold NUM_REGS, NUM_W, the FSM state typedef (IDLE, OFFER), and the bit-to-register-number mapping function.
REQ-026 Sub-module reg_prio_sel (combinational: request vector plus start index in, one-hot grant plus index out) SHALL implement the search; the FSM SHALL be in reg_encoder.

Verification
REQ-027 Reset, then reg_req = 8'b00100000, num_ready = 1 -> cycle 1 num_valid = 1, reg_num = 16'h0002; cycle 2 reg_ack = 8'b00100000, num_valid = 0.
REQ-028 reg_req = 8'b10000001, num_ready held 0 for 5 cycles -> reg_num = 16'h0000 stable and valid for all 5 cycles, reg_ack = 0; num_ready = 1 -> single ack 8'b10000000.
REQ-029 Round-robin build, reg_req = 8'hFF constant, num_ready = 1 -> grant order 0,1,...,7,0 across 9 handshakes; fixed build -> register 0 every time.
REQ-030 Offer of register 3 pending, drop reg_req bit 4 then assert num_ready -> reg_ack = 8'b00010000 still issued.
REQ-031 rst pulsed mid-OFFER (not aligned to clk) -> num_valid, reg_num, reg_ack go 0 immediately; no ack pulse after release.
REQ-032 reg_req = 0, num_ready toggling for 10 cycles -> num_valid, reg_ack, busy remain 0.
